// File: rtl/overture_out_monitor_if.sv
// Show-ahead output stream of the Overture out_port monitor: captured value plus
// the run-cycle timestamp taken when that value was sampled.
interface overture_out_monitor_if #(
    parameter int STAMP_W = 16
);
    logic               m_valid;
    logic               m_ready;
    logic [7:0]         m_data;
    logic [STAMP_W-1:0] m_stamp;

    modport master (output m_valid, output m_data, output m_stamp, input m_ready);
    modport slave  (input m_valid, input m_data, input m_stamp, output m_ready);
endinterface

// File: rtl/overture_out_monitor.sv
// Watches an Overture CPU's out_port/pc, queues every out_port change with a
// run-cycle timestamp in a show-ahead FIFO, and flags program halt.
module overture_out_monitor #(
    parameter int DEPTH       = 8,
    parameter int HALT_CYCLES = 4,
    parameter int STAMP_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [7:0]               pc,
    input  logic [7:0]               out_port,
    overture_out_monitor_if.master   m,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     halted,
    output logic [STAMP_W-1:0]       cycle_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int HC_W  = $clog2(HALT_CYCLES + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [HC_W-1:0]  HALT_LIM = HC_W'(HALT_CYCLES);

    logic [7:0]         mem_data [DEPTH];
    logic [STAMP_W-1:0] mem_stamp[DEPTH];

    logic [7:0]         prev_out_reg,    prev_out_next;
    logic [7:0]         prev_pc_reg,     prev_pc_next;
    logic [HC_W-1:0]    stable_cnt_reg,  stable_cnt_next;
    logic               halted_reg,      halted_next;
    logic               overflow_reg,    overflow_next;
    logic [STAMP_W-1:0] cycle_count_reg, cycle_count_next;
    logic [PTR_W-1:0]   wr_ptr_reg,      wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg,      rd_ptr_next;
    logic [CNT_W-1:0]   count_reg,       count_next;

    logic push, pop, push_ok, fifo_valid;
    logic [HC_W-1:0] stable_calc;

    assign fifo_valid = (count_reg != '0);
    assign pop        = fifo_valid && m.m_ready;
    assign push       = run && (out_port != prev_out_reg);
    // A full FIFO still takes the new entry when the head leaves on the same edge.
    assign push_ok    = push && ((count_reg != FULL) || pop);

    always_comb begin
        stable_calc      = '0;
        prev_out_next    = prev_out_reg;
        prev_pc_next     = prev_pc_reg;
        stable_cnt_next  = stable_cnt_reg;
        halted_next      = halted_reg;
        overflow_next    = overflow_reg;
        cycle_count_next = cycle_count_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        count_next       = count_reg;

        if (pc == prev_pc_reg) begin
            stable_calc = (stable_cnt_reg == HALT_LIM) ? HALT_LIM : stable_cnt_reg + 1'b1;
        end

        if (run) begin
            prev_out_next   = out_port;
            prev_pc_next    = pc;
            stable_cnt_next = stable_calc;
            if (stable_calc == HALT_LIM) begin
                halted_next = 1'b1;
            end
            if (!halted_reg && (cycle_count_reg != '1)) begin
                cycle_count_next = cycle_count_reg + 1'b1;
            end
        end

        if (push && !push_ok) begin
            overflow_next = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_out_reg    <= '0;
            prev_pc_reg     <= '0;
            stable_cnt_reg  <= '0;
            halted_reg      <= 1'b0;
            overflow_reg    <= 1'b0;
            cycle_count_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            prev_out_reg    <= prev_out_next;
            prev_pc_reg     <= prev_pc_next;
            stable_cnt_reg  <= stable_cnt_next;
            halted_reg      <= halted_next;
            overflow_reg    <= overflow_next;
            cycle_count_reg <= cycle_count_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
        end
    end

    // Storage needs no reset: entries are only visible through count_reg.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_data[wr_ptr_reg]  <= out_port;
            mem_stamp[wr_ptr_reg] <= cycle_count_reg;
        end
    end

    assign m.m_valid   = fifo_valid;
    assign m.m_data    = fifo_valid ? mem_data[rd_ptr_reg]  : '0;
    assign m.m_stamp   = fifo_valid ? mem_stamp[rd_ptr_reg] : '0;
    assign fifo_count  = count_reg;
    assign overflow    = overflow_reg;
    assign halted      = halted_reg;
    assign cycle_count = cycle_count_reg;
endmodule

// File: doc/overture_out_monitor.md
Name: overture_out_monitor

Overview:
- Downstream consumer of an Overture CPU program wrapper (e.g. pgm_overture_* instances).
- Watches the CPU's out_port and pc while the CPU runs and captures every out_port value change into a show-ahead FIFO, tagged with a run-cycle timestamp.
- Drains the FIFO over a valid/ready stream to the bench or scoreboard.
- Detects program halt (pc constant for HALT_CYCLES run cycles) and keeps a saturating run-cycle counter.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
HALT_CYCLES, 4, consecutive run cycles with unchanged pc that declare halt; >= 1
STAMP_W, 16, width of the cycle counter and timestamp

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
run  input  1  same run signal driven to the CPU; sampling enabled only when high
pc  input  8  CPU program counter
out_port  input  8  CPU output port
m_valid  output  1  FIFO head entry available
m_ready  input  1  consumer accepts head entry when m_valid && m_ready
m_data  output  8  captured out_port value at head
m_stamp  output  STAMP_W  cycle_count value at capture time of head entry
fifo_count  output  $clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky: an event was dropped because the FIFO was full
halted  output  1  sticky: halt detected
cycle_count  output  STAMP_W  run cycles elapsed before halt, saturating

Behaviour:
- Reset (synchronous): prev_out=0, prev_pc=0, stable_cnt=0, FIFO empty, fifo_count=0, m_valid=0, m_data=0, m_stamp=0, overflow=0, halted=0, cycle_count=0.
- Sample cycle: any rising edge with run=1 and reset=0. With run=0, prev_out, prev_pc, stable_cnt and cycle_count hold. Draining continues regardless of run.
- Capture: on a sample cycle with out_port != prev_out, raise push with entry {out_port, cycle_count} (pre-increment value). prev_out <= out_port on every sample cycle. An initial out_port of 0 is never captured.
- Capture is not gated by halted, so a final write after halt is still recorded.
- FIFO: circular buffer with wrapping read/write pointers and a separate count.
  - Pop = m_valid && m_ready.
  - Push is accepted if count<DEPTH, or if count==DEPTH and pop occurs in the same cycle (the freed slot is reused).
  - A push that is not accepted is dropped and sets overflow. overflow clears only on reset.
  - Simultaneous accepted push and pop: count unchanged.
- Show-ahead output: m_valid = (count!=0). m_data and m_stamp are the head entry, driven combinationally from storage. An entry pushed at edge k is visible from cycle k+1 (1-cycle latency). While m_valid=1 and pop=0, m_data and m_stamp are stable.
- Halt detect, on each sample cycle:
  - If pc==prev_pc, stable_cnt increments, saturating at HALT_CYCLES.
  - Otherwise stable_cnt=0.
  - prev_pc <= pc.
  - halted is set on the edge where stable_cnt reaches HALT_CYCLES, and stays set until reset.
- cycle_count: increments on each sample cycle while halted=0. It saturates at 2^STAMP_W-1 and freezes once halted=1.
- Reset asserted mid-operation discards all FIFO contents and flags in the same edge; reset takes priority over push/pop.

Test Plan:
- Reset behaviour: reset=1 for 2 cycles with m_ready=0, then run=1 and pc incrementing 0,1,2…, out_port=0 -> m_valid=0, fifo_count=0, overflow=0, halted=0, cycle_count counts 1,2,3…
- Single capture: out_port changes 0->0x2A while the prior sample cycle had cycle_count=5, m_ready=0 -> next cycle m_valid=1, m_data=0x2A, m_stamp=5, fifo_count=1. Holding 0x2A produces no further entries.
- Order and drain: out_port sequence 3,3,7,1, one value per run cycle, with m_ready=1 -> entries 3,7,1 drained in order with increasing stamps; fifo_count returns to 0.
- Overflow: m_ready=0, DEPTH=8, ten distinct values -> fifo_count=8, overflow=1. Drain yields the first 8 values. Full FIFO plus simultaneous pop and push -> no overflow, count stays 8.
- Halt: pc held at 0x14 for 4 run cycles (HALT_CYCLES=4) -> halted=1 and cycle_count frozen. pc changing afterwards leaves halted=1. run=0 for 3 cycles beforehand pauses stable_cnt without clearing it.
- Reset mid-drain: 3 entries queued, overflow=1, halted=1; assert reset for one edge -> all outputs return to reset values the following cycle.
